// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Shared types and constants for the instruction-fetch slice.
//   - XLEN / INSTR_BYTES      : datapath width and instruction size in bytes
//   - DEFAULT_RESET_PC        : default PC loaded on reset
//   - fetch_entry_t           : {pc, instr} pair buffered between fetch and decode
//   - fetch_state_t           : fetch FSM states (RUN, HALT after misaligned trap)
//   - pc_plus4 / is_misaligned: small PC helpers shared by fetch logic
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_t;

    // Sequential next PC; wraps modulo 2^32 by construction of the 32-bit add.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

    // A fetch target must be word aligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage : riscv_pkg

// File: rtl/pc_fetch_unit_fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//   QDEPTH-entry FIFO of fetch_entry_t between the PC stage and decode.
//   Flush has priority over push and pop; a push into a full queue is only
//   accepted when a pop happens in the same cycle.
// Ports
//   clk      in   clock
//   rst      in   synchronous active-low reset
//   flush_i  in   drop all entries at the next posedge
//   push_i   in   write entry_i at the tail
//   entry_i  in   {pc, instr} to enqueue
//   pop_i    in   remove the head entry
//   full_o   out  count == QDEPTH
//   empty_o  out  count == 0
//   head_o   out  current head entry (registered storage)
// ----------------------------------------------------------------------------
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    fetch_entry_t   mem_q [QDEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push_s;
    logic           do_pop_s;

    assign full_o  = (count_q == CW'(QDEPTH));
    assign empty_o = (count_q == {CW{1'b0}});
    assign head_o  = mem_q[head_q];

    // Qualify push/pop and compute next pointers and occupancy.
    always_comb begin
        do_pop_s  = pop_i & ~empty_o;
        do_push_s = push_i & (~full_o | do_pop_s);
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush_i) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            // Pointers wrap naturally because QDEPTH is a power of two.
            if (do_pop_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            if (do_push_s) begin
                tail_d = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer, occupancy and storage registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (do_push_s && !flush_i) begin
                mem_q[tail_q] <= entry_i;
            end
        end
    end

endmodule : fetch_queue

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
//   Instruction-fetch stage in front of Instrmem. Owns the PC, presents it as
//   the memory address, captures the returned instruction in the same cycle
//   and queues {pc, instr} pairs for decode over a valid/ready handshake.
//   Redirects flush the queue and load a new PC; a misaligned redirect target
//   halts fetching with a sticky trap until reset.
// Ports
//   clk                in   clock
//   rst                in   synchronous active-low reset
//   imem_addr_o        out  fetch address (= pc)
//   imem_instr_i       in   instruction read at imem_addr_o
//   redirect_i         in   taken branch/jump this cycle
//   redirect_target_i  in   new PC on redirect
//   fetch_valid_o      out  queue head valid
//   fetch_ready_i      in   decode accepts the head
//   fetch_instr_o      out  head instruction
//   fetch_pc_o         out  head PC
//   fetch_pc4_o        out  head PC + 4 (link value)
//   trap_o             out  sticky misaligned-fetch trap
//   fetch_count_o      out  number of handshaked instructions (wraps)
// ----------------------------------------------------------------------------
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic [31:0] fetch_pc4_o,
    output logic        trap_o,
    output logic [31:0] fetch_count_o
);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   count_q, count_d;

    logic          q_full_s;
    logic          q_empty_s;
    fetch_entry_t  q_head_s;
    fetch_entry_t  q_entry_s;
    logic          deq_s;
    logic          enq_s;

    assign imem_addr_o   = pc_q;
    assign fetch_valid_o = ~q_empty_s;
    assign fetch_pc_o    = q_head_s.pc;
    assign fetch_instr_o = q_head_s.instr;
    assign fetch_pc4_o   = pc_plus4(q_head_s.pc);
    assign trap_o        = (state_q == FS_HALT);
    assign fetch_count_o = count_q;

    assign q_entry_s = '{pc: pc_q, instr: imem_instr_i};

    // Handshake and enqueue qualification. A redirect takes priority over
    // fetching, and a full queue can still accept when the head leaves.
    always_comb begin
        deq_s = fetch_valid_o & fetch_ready_i;
        enq_s = ~trap_o & ~redirect_i & (~q_full_s | deq_s);
    end

    // Next PC: redirect target, sequential advance, or hold when stalled.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_target_i;
        end else if (enq_s) begin
            pc_d = pc_plus4(pc_q);
        end else begin
            pc_d = pc_q;
        end
    end

    // Fetch FSM: a misaligned redirect halts fetching; only reset resumes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_RUN: begin
                if (redirect_i && is_misaligned(redirect_target_i)) begin
                    state_d = FS_HALT;
                end else begin
                    state_d = FS_RUN;
                end
            end
            FS_HALT: state_d = FS_HALT;
            default: state_d = FS_HALT;
        endcase
    end

    // Dequeue counter; deliberately wraps at 2^32.
    always_comb begin
        count_d = count_q;
        if (deq_s) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
    end

    // PC, FSM and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            state_q <= FS_RUN;
            count_q <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_i),
        .push_i  (enq_s),
        .entry_i (q_entry_s),
        .pop_i   (deq_s),
        .full_o  (q_full_s),
        .empty_o (q_empty_s),
        .head_o  (q_head_s)
    );

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Directed bench for pc_fetch_unit. Instrmem is modelled as
//   instr = addr ^ 32'hA5A5_0000. Each step drives inputs, lets one posedge
//   pass and compares the post-edge outputs with hand-computed values.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr_s;
    logic [31:0] imem_instr_s;
    logic        redirect_s;
    logic [31:0] target_s;
    logic        valid_s;
    logic        ready_s;
    logic [31:0] instr_s;
    logic [31:0] pc_s;
    logic [31:0] pc4_s;
    logic        trap_s;
    logic [31:0] count_s;

    int n_vec;
    int n_err;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] tgt;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic        e_trap;
        logic [31:0] e_count;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_addr_o       (imem_addr_s),
        .imem_instr_i      (imem_instr_s),
        .redirect_i        (redirect_s),
        .redirect_target_i (target_s),
        .fetch_valid_o     (valid_s),
        .fetch_ready_i     (ready_s),
        .fetch_instr_o     (instr_s),
        .fetch_pc_o        (pc_s),
        .fetch_pc4_o       (pc4_s),
        .trap_o            (trap_s),
        .fetch_count_o     (count_s)
    );

    assign imem_instr_s = imem_addr_s ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %h expected %h", tag, field, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic redir,
                        input logic [31:0] tgt, input logic rdy);
        rst        = r;
        redirect_s = redir;
        target_s   = tgt;
        ready_s    = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic e_valid,
                         input logic [31:0] e_pc, input logic [31:0] e_addr,
                         input logic e_trap, input logic [31:0] e_count);
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        e_instr = e_pc ^ 32'hA5A5_0000;
        e_pc4   = e_pc + 32'd4;
        n_vec++;
        cmp(tag, "valid", {31'd0, valid_s}, {31'd0, e_valid});
        cmp(tag, "addr",  imem_addr_s, e_addr);
        cmp(tag, "trap",  {31'd0, trap_s}, {31'd0, e_trap});
        cmp(tag, "count", count_s, e_count);
        if (e_valid) begin
            cmp(tag, "pc",    pc_s,    e_pc);
            cmp(tag, "instr", instr_s, e_instr);
            cmp(tag, "pc4",   pc4_s,   e_pc4);
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b0;
        redirect_s = 1'b0;
        target_s   = 32'h0;
        ready_s    = 1'b0;

        //            rst   redir tgt           rdy   valid pc            addr          trap  count
        // Reset, then streaming with ready=1
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 32'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'h4,        1'b0, 32'd0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'h8,        1'b0, 32'd1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'hC,        1'b0, 32'd2};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        32'h10,       1'b0, 32'd3};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       32'h14,       1'b0, 32'd4};
        // Reset, then back-pressure: two pushes, pc holds at 8
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'd0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h4,        1'b0, 32'd0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h8,        1'b0, 32'd0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h8,        1'b0, 32'd0};
        vecs[10] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h8,        1'b0, 32'd0};
        vecs[11] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h8,        1'b0, 32'd0};
        // Release: full with deq still enqueues, order 0,4,8
        vecs[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'hC,        1'b0, 32'd1};
        vecs[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'h10,       1'b0, 32'd2};
        vecs[14] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        32'h10,       1'b0, 32'd2};
        // Redirect with two entries queued flushes them
        vecs[15] = '{1'b1, 1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        32'h100,      1'b0, 32'd2};
        vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h100,      32'h104,      1'b0, 32'd2};
        // Redirect together with a deq: the deq still counts
        vecs[17] = '{1'b1, 1'b1, 32'h200,      1'b1, 1'b0, 32'h0,        32'h200,      1'b0, 32'd3};
        vecs[18] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200,      32'h204,      1'b0, 32'd3};
        vecs[19] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h204,      32'h208,      1'b0, 32'd4};

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].redir, vecs[i].tgt, vecs[i].rdy);
            check($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                  vecs[i].e_addr, vecs[i].e_trap, vecs[i].e_count);
        end

        // Misaligned redirect: head 204 is dequeued in the same cycle
        step(1'b1, 1'b1, 32'h102, 1'b1);
        check("trap_set", 1'b0, 32'h0, 32'h102, 1'b1, 32'd5);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            check($sformatf("trap_hold%0d", i), 1'b0, 32'h0, 32'h102, 1'b1, 32'd5);
        end
        // Redirect while trapped: pc moves, trap and empty queue persist
        step(1'b1, 1'b1, 32'h300, 1'b1);
        check("trap_redir", 1'b0, 32'h0, 32'h300, 1'b1, 32'd5);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("trap_redir_hold", 1'b0, 32'h0, 32'h300, 1'b1, 32'd5);
        // One-cycle reset clears the trap and restarts at 0
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("trap_rst", 1'b0, 32'h0, 32'h0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("trap_restart", 1'b1, 32'h0, 32'h4, 1'b0, 32'd0);

        // PC wrap: FFFF_FFFC then 0; first head has pc4 = 0
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        check("wrap_redir", 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_head0", 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'd0);
        cmp("wrap_head0", "pc4_zero", pc4_s, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_head1", 1'b1, 32'h0, 32'h4, 1'b0, 32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_head2", 1'b1, 32'h4, 32'h8, 1'b0, 32'd2);

        // Reset dominates a simultaneous redirect and deq
        step(1'b0, 1'b1, 32'h400, 1'b1);
        check("rst_dominates", 1'b0, 32'h0, 32'h0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("rst_restart", 1'b1, 32'h0, 32'h4, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pc_fetch_unit
